// File: rtl/mem_access.sv
// mem_access: minuteCore memory stage -- issues LOAD/STORE on the dmem port, aligns load data, passes ALU results and exceptions through.
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int EX_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PC_in,
    input  logic [EX_W-1:0]   exception_in,
    input  logic              exception_in_valid,
    input  logic              pipeline_in_valid,
    input  logic [4:0]        opcode_in,
    input  logic [2:0]        funct_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [4:0]        rd_addr_in,
    input  logic              rd_wr_enable_in,
    input  logic              nop_instr_in,
    input  logic              flush,
    output logic              stall,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_rd_enable,
    output logic              dmem_wr_enable,
    output logic [DATA_W-1:0] dmem_wr_data,
    output logic [3:0]        dmem_wr_strobe,
    input  logic [DATA_W-1:0] dmem_rd_data,
    input  logic              dmem_ready,
    output logic [ADDR_W-1:0] PC_out,
    output logic [EX_W-1:0]   exception_out,
    output logic              exception_out_valid,
    output logic              pipeline_out_valid,
    output logic [4:0]        rd_addr_out,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              rd_wr_enable_out
);
    localparam logic STATE_IDLE     = 1'b0;
    localparam logic STATE_MEM_WAIT = 1'b1;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    localparam logic [EX_W-1:0] EXC_ILLEGAL        = EX_W'(2);
    localparam logic [EX_W-1:0] EXC_LOAD_MISALIGN  = EX_W'(4);
    localparam logic [EX_W-1:0] EXC_STORE_MISALIGN = EX_W'(6);

    logic              state;
    logic              flush_pending;
    logic [ADDR_W-1:0] pend_pc;
    logic [4:0]        pend_rd;
    logic              pend_wr;
    logic [2:0]        pend_funct;
    logic [1:0]        pend_off;

    logic              is_load;
    logic              is_store;
    logic              is_mem;
    logic              funct_illegal;
    logic              misaligned;
    logic [3:0]        store_strobe;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_data;
    logic              discard;

    assign stall = (state == STATE_MEM_WAIT);

    // Classify the incoming bundle and build the store lane pattern from the low address bits.
    always_comb begin
        is_load       = (opcode_in == OP_LOAD) && !nop_instr_in && !exception_in_valid;
        is_store      = (opcode_in == OP_STORE) && !nop_instr_in && !exception_in_valid;
        is_mem        = is_load || is_store;
        funct_illegal = is_load ? (funct_in == 3'b011 || funct_in[2:1] == 2'b11)
                                : (is_store && funct_in >= 3'b011);
        misaligned    = (funct_in[1:0] == 2'b01 && result_in[0])
                     || (funct_in[1:0] == 2'b10 && result_in[1:0] != 2'b00);
        store_strobe  = (funct_in[1:0] == 2'b00) ? 4'b0001 << result_in[1:0]
                      : (funct_in[1:0] == 2'b01) ? 4'b0011 << {result_in[1], 1'b0}
                      : 4'b1111;
        store_data    = (funct_in[1:0] == 2'b00) ? {4{store_data_in[7:0]}}
                      : (funct_in[1:0] == 2'b01) ? {2{store_data_in[15:0]}}
                      : store_data_in;
    end

    // Select the addressed byte/half from the returned word and sign- or zero-extend it (funct[2] marks unsigned).
    always_comb begin
        shifted   = dmem_rd_data >> {pend_off, 3'b000};
        load_data = (pend_funct[1:0] == 2'b00) ? {{24{~pend_funct[2] & shifted[7]}}, shifted[7:0]}
                  : (pend_funct[1:0] == 2'b01) ? {{16{~pend_funct[2] & shifted[15]}}, shifted[15:0]}
                  : dmem_rd_data;
        discard   = flush || flush_pending;
    end

    // Stage state machine: accept in IDLE, hold the dmem request in MEM_WAIT until ready, then retire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= STATE_IDLE;
            flush_pending       <= 1'b0;
            pend_pc             <= '0;
            pend_rd             <= '0;
            pend_wr             <= 1'b0;
            pend_funct          <= '0;
            pend_off            <= '0;
            dmem_addr           <= '0;
            dmem_rd_enable      <= 1'b0;
            dmem_wr_enable      <= 1'b0;
            dmem_wr_data        <= '0;
            dmem_wr_strobe      <= '0;
            PC_out              <= '0;
            exception_out       <= '0;
            exception_out_valid <= 1'b0;
            pipeline_out_valid  <= 1'b0;
            rd_addr_out         <= '0;
            rd_data_out         <= '0;
            rd_wr_enable_out    <= 1'b0;
        end else if (state == STATE_IDLE) begin
            if (pipeline_in_valid && !flush) begin
                if (is_mem && !funct_illegal && !misaligned) begin
                    state              <= STATE_MEM_WAIT;
                    dmem_addr          <= {result_in[ADDR_W-1:2], 2'b00};
                    dmem_rd_enable     <= is_load;
                    dmem_wr_enable     <= is_store;
                    dmem_wr_data       <= is_store ? store_data : '0;
                    dmem_wr_strobe     <= is_store ? store_strobe : 4'b0000;
                    pend_pc            <= PC_in;
                    pend_rd            <= rd_addr_in;
                    pend_wr            <= rd_wr_enable_in;
                    pend_funct         <= funct_in;
                    pend_off           <= result_in[1:0];
                    pipeline_out_valid <= 1'b0;
                end else begin
                    PC_out             <= PC_in;
                    rd_addr_out        <= rd_addr_in;
                    rd_data_out        <= result_in;
                    pipeline_out_valid <= 1'b1;
                    if (is_mem) begin
                        exception_out       <= funct_illegal ? EXC_ILLEGAL
                                             : is_load ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
                        exception_out_valid <= 1'b1;
                        rd_wr_enable_out    <= 1'b0;
                    end else begin
                        exception_out       <= exception_in_valid ? exception_in : '0;
                        exception_out_valid <= exception_in_valid;
                        rd_wr_enable_out    <= rd_wr_enable_in && !exception_in_valid && !nop_instr_in;
                    end
                end
            end else begin
                pipeline_out_valid <= 1'b0;
            end
        end else if (dmem_ready) begin
            state               <= STATE_IDLE;
            dmem_rd_enable      <= 1'b0;
            dmem_wr_enable      <= 1'b0;
            dmem_wr_strobe      <= 4'b0000;
            flush_pending       <= 1'b0;
            PC_out              <= pend_pc;
            rd_addr_out         <= pend_rd;
            rd_data_out         <= dmem_rd_enable ? load_data : '0;
            exception_out       <= '0;
            exception_out_valid <= 1'b0;
            pipeline_out_valid  <= !discard;
            rd_wr_enable_out    <= !discard && dmem_rd_enable && pend_wr && (pend_rd != 5'd0);
        end else if (flush) begin
            flush_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed-vector bench for the mem_access stage.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PC_in = '0;
    logic [3:0]  exception_in = '0;
    logic        exception_in_valid = 1'b0;
    logic        pipeline_in_valid = 1'b0;
    logic [4:0]  opcode_in = '0;
    logic [2:0]  funct_in = '0;
    logic [31:0] result_in = '0;
    logic [31:0] store_data_in = '0;
    logic [4:0]  rd_addr_in = '0;
    logic        rd_wr_enable_in = 1'b0;
    logic        nop_instr_in = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] dmem_addr;
    logic        dmem_rd_enable;
    logic        dmem_wr_enable;
    logic [31:0] dmem_wr_data;
    logic [3:0]  dmem_wr_strobe;
    logic [31:0] dmem_rd_data = '0;
    logic        dmem_ready = 1'b0;
    logic [31:0] PC_out;
    logic [3:0]  exception_out;
    logic        exception_out_valid;
    logic        pipeline_out_valid;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_data_out;
    logic        rd_wr_enable_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;

    localparam logic [4:0] LOAD  = 5'b00000;
    localparam logic [4:0] STORE = 5'b01000;
    localparam logic [4:0] ALU   = 5'b01100;

    mem_access dut (
        .clk(clk), .reset(reset), .PC_in(PC_in), .exception_in(exception_in),
        .exception_in_valid(exception_in_valid), .pipeline_in_valid(pipeline_in_valid),
        .opcode_in(opcode_in), .funct_in(funct_in), .result_in(result_in),
        .store_data_in(store_data_in), .rd_addr_in(rd_addr_in), .rd_wr_enable_in(rd_wr_enable_in),
        .nop_instr_in(nop_instr_in), .flush(flush), .stall(stall), .dmem_addr(dmem_addr),
        .dmem_rd_enable(dmem_rd_enable), .dmem_wr_enable(dmem_wr_enable),
        .dmem_wr_data(dmem_wr_data), .dmem_wr_strobe(dmem_wr_strobe),
        .dmem_rd_data(dmem_rd_data), .dmem_ready(dmem_ready), .PC_out(PC_out),
        .exception_out(exception_out), .exception_out_valid(exception_out_valid),
        .pipeline_out_valid(pipeline_out_valid), .rd_addr_out(rd_addr_out),
        .rd_data_out(rd_data_out), .rd_wr_enable_out(rd_wr_enable_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [4:0] op, input logic [2:0] f, input logic [31:0] res,
                        input logic [31:0] sd, input logic [4:0] rd, input logic wr);
        opcode_in         = op;
        funct_in          = f;
        result_in         = res;
        store_data_in     = sd;
        rd_addr_in        = rd;
        rd_wr_enable_in   = wr;
        PC_in             = res + 32'h1000;
        pipeline_in_valid = 1'b1;
        @(posedge clk);
        #1;
        pipeline_in_valid = 1'b0;
    endtask

    task automatic wait_ready(input int delay, output int stalled);
        stalled = 0;
        while (stall && stalled < 20) begin
            stalled++;
            if (stalled == delay) dmem_ready = 1'b1;
            @(posedge clk);
            #1;
            dmem_ready = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rd_en", 32'(dmem_rd_enable), 32'd0);
        check("rst_wr_en", 32'(dmem_wr_enable), 32'd0);
        check("rst_strobe", 32'(dmem_wr_strobe), 32'd0);
        check("rst_valid", 32'(pipeline_out_valid), 32'd0);
        check("rst_rd_data", rd_data_out, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        send(ALU, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
        check("alu_data", rd_data_out, 32'h1234);
        check("alu_rd", 32'(rd_addr_out), 32'd5);
        check("alu_valid", 32'(pipeline_out_valid), 32'd1);
        check("alu_wr", 32'(rd_wr_enable_out), 32'd1);
        check("alu_pc", PC_out, 32'h2234);
        check("alu_no_rd", 32'(dmem_rd_enable), 32'd0);
        check("alu_no_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        check("idle_valid", 32'(pipeline_out_valid), 32'd0);

        dmem_rd_data = 32'h80FF7F01;
        send(LOAD, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1);
        check("lb_rd_en", 32'(dmem_rd_enable), 32'd1);
        check("lb_addr", dmem_addr, 32'h100);
        check("lb_wait_valid", 32'(pipeline_out_valid), 32'd0);
        wait_ready(3, cnt);
        check("lb_stall_cycles", cnt, 32'd3);
        check("lb_data", rd_data_out, 32'hFFFFFF80);
        check("lb_valid", 32'(pipeline_out_valid), 32'd1);
        check("lb_wr", 32'(rd_wr_enable_out), 32'd1);
        check("lb_rd_en_off", 32'(dmem_rd_enable), 32'd0);

        send(LOAD, 3'b100, 32'h103, 32'h0, 5'd7, 1'b1);
        wait_ready(1, cnt);
        check("lbu_stall_cycles", cnt, 32'd1);
        check("lbu_data", rd_data_out, 32'h00000080);

        send(LOAD, 3'b001, 32'h102, 32'h0, 5'd8, 1'b1);
        wait_ready(1, cnt);
        check("lh_data", rd_data_out, 32'hFFFF80FF);

        send(LOAD, 3'b101, 32'h100, 32'h0, 5'd8, 1'b1);
        wait_ready(2, cnt);
        check("lhu_data", rd_data_out, 32'h00007F01);

        send(LOAD, 3'b010, 32'h100, 32'h0, 5'd0, 1'b1);
        wait_ready(1, cnt);
        check("lw_data", rd_data_out, 32'h80FF7F01);
        check("lw_x0_wr", 32'(rd_wr_enable_out), 32'd0);

        send(STORE, 3'b001, 32'h102, 32'h0000ABCD, 5'd9, 1'b1);
        check("sh_addr", dmem_addr, 32'h100);
        check("sh_strobe", 32'(dmem_wr_strobe), 32'hC);
        check("sh_data", dmem_wr_data, 32'hABCDABCD);
        check("sh_wr_en", 32'(dmem_wr_enable), 32'd1);
        check("sh_rd_en", 32'(dmem_rd_enable), 32'd0);
        wait_ready(2, cnt);
        check("sh_valid", 32'(pipeline_out_valid), 32'd1);
        check("sh_rd_wr", 32'(rd_wr_enable_out), 32'd0);
        check("sh_wr_en_off", 32'(dmem_wr_enable), 32'd0);

        send(STORE, 3'b000, 32'h101, 32'h12345678, 5'd9, 1'b0);
        check("sb_strobe", 32'(dmem_wr_strobe), 32'h2);
        check("sb_data", dmem_wr_data, 32'h78787878);
        wait_ready(1, cnt);

        send(LOAD, 3'b010, 32'h102, 32'h0, 5'd4, 1'b1);
        check("lw_mis_code", 32'(exception_out), 32'd4);
        check("lw_mis_exv", 32'(exception_out_valid), 32'd1);
        check("lw_mis_rd_en", 32'(dmem_rd_enable), 32'd0);
        check("lw_mis_stall", 32'(stall), 32'd0);
        check("lw_mis_wr", 32'(rd_wr_enable_out), 32'd0);

        send(STORE, 3'b010, 32'h101, 32'h0, 5'd0, 1'b0);
        check("sw_mis_code", 32'(exception_out), 32'd6);
        check("sw_mis_wr_en", 32'(dmem_wr_enable), 32'd0);

        send(LOAD, 3'b011, 32'h100, 32'h0, 5'd4, 1'b1);
        check("ld_ill_code", 32'(exception_out), 32'd2);
        check("ld_ill_rd_en", 32'(dmem_rd_enable), 32'd0);

        exception_in_valid = 1'b1;
        exception_in = 4'd3;
        send(LOAD, 3'b010, 32'h100, 32'h0, 5'd4, 1'b1);
        exception_in_valid = 1'b0;
        check("up_exc_code", 32'(exception_out), 32'd3);
        check("up_exc_valid", 32'(exception_out_valid), 32'd1);
        check("up_exc_rd_en", 32'(dmem_rd_enable), 32'd0);
        check("up_exc_wr", 32'(rd_wr_enable_out), 32'd0);

        send(LOAD, 3'b010, 32'h200, 32'h0, 5'd6, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fl_rd_en_held", 32'(dmem_rd_enable), 32'd1);
        check("fl_stall_held", 32'(stall), 32'd1);
        wait_ready(2, cnt);
        check("fl_valid", 32'(pipeline_out_valid), 32'd0);
        check("fl_rd_en_off", 32'(dmem_rd_enable), 32'd0);

        send(LOAD, 3'b010, 32'h200, 32'h0, 5'd6, 1'b1);
        flush = 1'b1;
        dmem_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        dmem_ready = 1'b0;
        check("fl_rdy_valid", 32'(pipeline_out_valid), 32'd0);
        check("fl_rdy_stall", 32'(stall), 32'd0);

        flush = 1'b1;
        send(ALU, 3'b000, 32'h55, 32'h0, 5'd5, 1'b1);
        flush = 1'b0;
        check("fl_idle_valid", 32'(pipeline_out_valid), 32'd0);

        send(ALU, 3'b000, 32'h77, 32'h0, 5'd5, 1'b1);
        check("post_fl_valid", 32'(pipeline_out_valid), 32'd1);

        send(LOAD, 3'b010, 32'h300, 32'h0, 5'd6, 1'b1);
        check("rw_rd_en", 32'(dmem_rd_enable), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rw_rd_en_drop", 32'(dmem_rd_enable), 32'd0);
        check("rw_stall_drop", 32'(stall), 32'd0);
        check("rw_valid", 32'(pipeline_out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(ALU, 3'b000, 32'h99, 32'h0, 5'd3, 1'b1);
        check("rw_recover", rd_data_out, 32'h99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
